spi_target_regfile: RTL and testbench

- SPI responder (target) that emulates an 8-bit-register peripheral at the far end of our SPI master, for closed-loop simulation and on-board loopback tests of the host-command → SPI master → FIFO path.
- Samples SCLK, CS_N and MOSI with the system clock, decodes 16-bit frames as register writes or reads, and drives MISO with register contents on reads.
- Provides a fabric-side port so logic or benches can preload and inspect registers, and a one-cycle write-strobe output for every completed SPI write frame.

---
 rtl/spi_target_regfile.sv | 248 ++++++++++++++++++++++++
 tb/tb_spi_target_regfile.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : spi_target_regfile
//  Purpose  : SPI target that emulates a bank of 8-bit registers. SCLK, CS_N
//             and MOSI are oversampled with clk. 16-bit frames
//             {rw, addr[6:0], data[7:0]}, MSB first, are decoded as register
//             writes (rw=0) or reads (rw=1). CPHA is fixed at 0.
//  Ports    : clk, rst_n          system clock, async active-low reset
//             sclk, cs_n, mosi    SPI pins (asynchronous to clk)
//             miso, miso_oe       SPI data out and its output enable
//             wr_valid/addr/data  one-clk strobe and fields of a write frame
//             frame_err           one-clk pulse when CS_N rises mid-frame
//             host_we/addr/wdata  fabric-side register write port
//             host_rdata          registered read of reg[host_addr]
//  Revision : 1.0  initial release
// ============================================================================
module spi_target_regfile #(
    parameter int          ADDR_W    = 4,
    parameter bit          CPOL      = 1'b0,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              wr_valid,
    output logic [6:0]        wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_err,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata
);

    localparam int c_num_regs = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases synchronously to clk.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Pin synchronizers. Stages [0],[1] synchronize, stage [2] is the
    // edge-detect history, so an event acts on the third clk after the pin.
    // The CS_N chain resets to "selected" so that a frame still in flight
    // across a reset produces no falling edge; only a genuine high-then-low
    // on CS_N can open the next frame.
    // ------------------------------------------------------------------
    logic [2:0] r_sclk_q;
    logic [2:0] r_cs_q;
    logic [1:0] r_mosi_q;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sclk_q <= {3{CPOL}};
            r_cs_q   <= 3'b000;
            r_mosi_q <= 2'b00;
        end else begin
            r_sclk_q <= {r_sclk_q[1:0], sclk};
            r_cs_q   <= {r_cs_q[1:0], cs_n};
            r_mosi_q <= {r_mosi_q[0], mosi};
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_samp, w_shift;
    logic w_cs_fall, w_cs_rise, w_mosi;

    assign w_sclk_rise = r_sclk_q[1] & ~r_sclk_q[2];
    assign w_sclk_fall = ~r_sclk_q[1] & r_sclk_q[2];
    assign w_samp      = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_shift     = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_cs_fall   = ~r_cs_q[1] & r_cs_q[2];
    assign w_cs_rise   = r_cs_q[1] & ~r_cs_q[2];
    assign w_mosi      = r_mosi_q[1];

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t       r_state, w_state_nxt;
    logic [3:0]   r_bitcnt;
    logic [6:0]   r_sr;          // bits received so far in the current byte
    logic         r_rw;
    logic [6:0]   r_addr;
    logic [7:0]   r_tx;
    logic [7:0]   r_regs [c_num_regs];

    logic         w_start, w_abort, w_cmd_done, w_frame_done, w_commit;
    logic [6:0]   w_cmd_addr;
    logic [7:0]   w_frame_data;
    logic         w_cmd_in_range, w_wr_in_range;

    // Command byte completes on the 8th sample: the 8th bit is still on mosi.
    assign w_cmd_addr     = {r_sr[5:0], w_mosi};
    assign w_frame_data   = {r_sr, w_mosi};
    assign w_cmd_in_range = (int'(w_cmd_addr) < c_num_regs);
    assign w_wr_in_range  = (int'(r_addr) < c_num_regs);
    assign w_commit       = w_frame_done & ~r_rw;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // CS_N rising is checked first so an abort always beats a coincident
    // SCLK event.
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        w_cmd_done   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_CMD;
                    w_start     = 1'b1;
                end
            end
            ST_CMD: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (w_samp && r_bitcnt == 4'd7) begin
                    w_state_nxt = ST_DATA;
                    w_cmd_done  = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (w_samp && r_bitcnt == 4'd15) begin
                    w_state_nxt  = ST_DONE;
                    w_frame_done = 1'b1;
                end
            end
            ST_DONE: begin
                if (w_cs_rise) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-in / shift-out datapath and output strobes
    // ------------------------------------------------------------------
    logic r_miso, r_miso_oe, r_wr_valid, r_frame_err;
    logic [6:0] r_wr_addr;
    logic [7:0] r_wr_data, r_host_rdata;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bitcnt    <= 4'd0;
            r_sr        <= 7'd0;
            r_rw        <= 1'b0;
            r_addr      <= 7'd0;
            r_tx        <= 8'd0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= 7'd0;
            r_wr_data   <= 8'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_miso_oe   <= (w_state_nxt != ST_IDLE);
            r_wr_valid  <= w_commit;
            r_frame_err <= w_abort;

            if (w_start) begin
                r_bitcnt <= 4'd0;
                r_sr     <= 7'd0;
                r_tx     <= 8'd0;
            end else if ((r_state == ST_CMD || r_state == ST_DATA) &&
                         w_samp && !w_cs_rise) begin
                r_sr     <= {r_sr[5:0], w_mosi};
                r_bitcnt <= r_bitcnt + 4'd1;
            end

            if (w_cmd_done) begin
                r_rw   <= r_sr[6];
                r_addr <= w_cmd_addr;
                if (r_sr[6] && w_cmd_in_range)
                    r_tx <= r_regs[w_cmd_addr[ADDR_W-1:0]];
                else
                    r_tx <= 8'h00;
            end

            // r_tx stays zero for writes, so miso only toggles on reads.
            if (w_state_nxt != ST_DATA) begin
                r_miso <= 1'b0;
            end else if (r_state == ST_DATA && w_shift) begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
            end

            if (w_commit) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_frame_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file. The SPI commit is written last, so it overrides a
    // host write to the same address in the same clk.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < c_num_regs; i++) r_regs[i] <= RESET_VAL;
            r_host_rdata <= 8'd0;
        end else begin
            r_host_rdata <= r_regs[host_addr];
            if (host_we)
                r_regs[host_addr] <= host_wdata;
            if (w_commit && w_wr_in_range)
                r_regs[r_addr[ADDR_W-1:0]] <= w_frame_data;
        end
    end

    assign miso       = r_miso;
    assign miso_oe    = r_miso_oe;
    assign wr_valid   = r_wr_valid;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_err  = r_frame_err;
    assign host_rdata = r_host_rdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_target_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_target_regfile
//  Purpose  : Directed bench for spi_target_regfile. Two instances share one
//             set of pins: dut0 runs CPOL=0 on sclk, dut1 runs CPOL=1 on the
//             inverted clock, so every directed step exercises both modes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_target_regfile;

    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [7:0] host_wdata = 8'h00;

    logic miso0, miso_oe0, wr_valid0, frame_err0;
    logic miso1, miso_oe1, wr_valid1, frame_err1;
    logic [6:0] wr_addr0, wr_addr1;
    logic [7:0] wr_data0, wr_data1, host_rdata0, host_rdata1;
    logic sclk_inv;

    assign sclk_inv = ~sclk;

    always #5 clk = ~clk;

    spi_target_regfile #(.ADDR_W(ADDR_W), .CPOL(1'b0), .RESET_VAL(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso0), .miso_oe(miso_oe0), .wr_valid(wr_valid0),
        .wr_addr(wr_addr0), .wr_data(wr_data0), .frame_err(frame_err0),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata0)
    );

    spi_target_regfile #(.ADDR_W(ADDR_W), .CPOL(1'b1), .RESET_VAL(8'h00)) dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_inv), .cs_n(cs_n), .mosi(mosi),
        .miso(miso1), .miso_oe(miso_oe1), .wr_valid(wr_valid1),
        .wr_addr(wr_addr1), .wr_data(wr_data1), .frame_err(frame_err1),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata1)
    );

    // Pulse counters
    int wv0 = 0, wv1 = 0, fe0 = 0, fe1 = 0;
    always @(posedge clk) begin
        wv0 <= wv0 + int'(wr_valid0);
        wv1 <= wv1 + int'(wr_valid1);
        fe0 <= fe0 + int'(frame_err0);
        fe1 <= fe1 + int'(frame_err1);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input logic [31:0] o0, input logic [31:0] o1,
                        input logic [31:0] exp, input string tag);
        chk(o0, exp, {tag, "_cpol0"});
        chk(o1, exp, {tag, "_cpol1"});
    endtask

    // SCLK half period = 5 clk, i.e. SCLK = clk/10
    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    logic [7:0] rd0, rd1;
    logic       cmd_nz, oe_seen0, oe_seen1;

    task automatic spi_begin();
        @(negedge clk);
        cs_n = 1'b0;
        rd0 = 8'h00; rd1 = 8'h00;
        cmd_nz = 1'b0; oe_seen0 = 1'b0; oe_seen1 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_end();
        half();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Sends bits [15-first .. 15-first-n+1] of frame. When coll is set, a host
    // write is issued on the clk where the 16th sample commits (3 clk after
    // the SCLK pin edge).
    task automatic spi_bits(input logic [15:0] frame, input int first, input int n,
                            input logic coll, input logic [3:0] caddr,
                            input logic [7:0] cdata);
        for (int i = first; i < first + n; i++) begin
            mosi = frame[15 - i];
            half();
            if (i < 8) cmd_nz = cmd_nz | miso0 | miso1;
            else begin
                rd0 = {rd0[6:0], miso0};
                rd1 = {rd1[6:0], miso1};
            end
            if (i == 4) begin oe_seen0 = miso_oe0; oe_seen1 = miso_oe1; end
            sclk = 1'b1;
            if (coll && i == 15) begin
                repeat (2) @(negedge clk);
                host_we = 1'b1; host_addr = caddr; host_wdata = cdata;
                @(negedge clk);
                host_we = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                half();
            end
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [15:0] frame);
        spi_begin();
        spi_bits(frame, 0, 16, 1'b0, 4'h0, 8'h00);
        spi_end();
    endtask

    task automatic host_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        host_addr = a;
        @(negedge clk);
        chk2(host_rdata0, host_rdata1, exp, tag);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    int wvs0, wvs1, fes0, fes1;

    task automatic snap();
        wvs0 = wv0; wvs1 = wv1; fes0 = fe0; fes1 = fe1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (4) @(negedge clk);
        chk2({miso0, miso_oe0, wr_valid0, frame_err0, wr_addr0, wr_data0, host_rdata0},
             {miso1, miso_oe1, wr_valid1, frame_err1, wr_addr1, wr_data1, host_rdata1},
             32'h0, "reset_outputs");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        host_read(4'hA, 8'h00, "reset_reg_a");

        // ---------------- write 0AA5 ----------------
        snap();
        spi_frame(16'h0AA5);
        chk2(wv0 - wvs0, wv1 - wvs1, 1, "wr0aa5_valid_cnt");
        chk2(wr_addr0, wr_addr1, 7'h0A, "wr0aa5_addr");
        chk2(wr_data0, wr_data1, 8'hA5, "wr0aa5_data");
        host_read(4'hA, 8'hA5, "wr0aa5_reg");

        // ---------------- read 8A00 ----------------
        snap();
        spi_frame(16'h8A00);
        chk2(rd0, rd1, 8'hA5, "rd8a00_miso");
        chk({31'd0, cmd_nz}, 0, "rd8a00_cmd_miso_zero");
        chk2(oe_seen0, oe_seen1, 1, "rd8a00_oe_in_frame");
        chk2(miso_oe0, miso_oe1, 0, "rd8a00_oe_after");
        chk2(wv0 - wvs0, wv1 - wvs1, 0, "rd8a00_no_wr_valid");

        // ---------------- abort after 10 bits ----------------
        snap();
        spi_begin();
        spi_bits(16'h0312, 0, 10, 1'b0, 4'h0, 8'h00);
        spi_end();
        chk2(fe0 - fes0, fe1 - fes1, 1, "abort_frame_err");
        chk2(wv0 - wvs0, wv1 - wvs1, 0, "abort_no_wr_valid");
        host_read(4'h3, 8'h00, "abort_reg3");
        snap();
        spi_frame(16'h0377);
        host_read(4'h3, 8'h77, "after_abort_reg3");
        chk2(fe0 - fes0, fe1 - fes1, 0, "after_abort_no_err");

        // ---------------- out of range ----------------
        host_write(4'h0, 8'hC3);
        snap();
        spi_frame(16'h3012);
        chk2(wv0 - wvs0, wv1 - wvs1, 1, "oor_wr_valid");
        chk2(wr_addr0, wr_addr1, 7'h30, "oor_wr_addr");
        host_read(4'h0, 8'hC3, "oor_reg0_kept");
        spi_frame(16'hB000);
        chk2(rd0, rd1, 8'h00, "oor_read_miso");

        // ---------------- collision ----------------
        spi_begin();
        spi_bits(16'h0522, 0, 16, 1'b1, 4'h5, 8'h11);
        spi_end();
        host_read(4'h5, 8'h22, "collision_reg5");

        // ---------------- reset mid-frame ----------------
        snap();
        spi_begin();
        spi_bits(16'h0312, 0, 6, 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk2({miso0, miso_oe0, wr_valid0, frame_err0, wr_addr0, wr_data0, host_rdata0},
             {miso1, miso_oe1, wr_valid1, frame_err1, wr_addr1, wr_data1, host_rdata1},
             32'h0, "midrst_outputs");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        host_read(4'hA, 8'h00, "midrst_reg_a");
        host_read(4'h3, 8'h00, "midrst_reg3");
        spi_bits(16'h0312, 6, 10, 1'b0, 4'h0, 8'h00);
        chk2(miso_oe0, miso_oe1, 0, "midrst_oe_stays_low");
        spi_end();
        chk2(wv0 - wvs0, wv1 - wvs1, 0, "midrst_no_wr_valid");
        spi_frame(16'h0155);
        host_read(4'h1, 8'h55, "midrst_next_frame_reg1");
        host_read(4'h3, 8'h00, "midrst_reg3_untouched");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
